// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer control path: state encodings,
// opcode classes, condition codes and well-known register selects.
package cpu_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    localparam logic [1:0] OP_IMM  = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_COPY = 2'b10;
    localparam logic [1:0] OP_COND = 2'b11;

    localparam logic [2:0] CC_NEVER  = 3'd0;
    localparam logic [2:0] CC_EQ     = 3'd1;
    localparam logic [2:0] CC_LT     = 3'd2;
    localparam logic [2:0] CC_LE     = 3'd3;
    localparam logic [2:0] CC_ALWAYS = 3'd4;
    localparam logic [2:0] CC_NE     = 3'd5;
    localparam logic [2:0] CC_GE     = 3'd6;
    localparam logic [2:0] CC_GT     = 3'd7;

    localparam logic [2:0] IMM_SEL      = 3'd0;
    localparam logic [2:0] ACC_SEL      = 3'd3;
    localparam logic [2:0] PORT_SEL     = 3'd6;
    localparam logic [2:0] UNMAPPED_SEL = 3'd7;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-memory fetch port: address plus req/ack handshake, data returned
// in the same cycle as ack.
interface control_sequencer_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/control_sequencer_cond_eval.sv
// Conditional-jump evaluator: decides whether a COND instruction is taken from
// its condition code and the signed condition operand.
module cond_eval
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [2:0]        cc,
    input  logic [DATA_W-1:0] cond_value,
    output logic              take
);
    logic is_zero_s;
    logic is_neg_s;

    assign is_zero_s = (cond_value == {DATA_W{1'b0}});
    assign is_neg_s  = cond_value[DATA_W-1];

    // Condition truth table on the two's-complement operand.
    always_comb begin
        take = 1'b0;
        case (cc)
            CC_NEVER:  take = 1'b0;
            CC_EQ:     take = is_zero_s;
            CC_LT:     take = is_neg_s;
            CC_LE:     take = is_neg_s | is_zero_s;
            CC_ALWAYS: take = 1'b1;
            CC_NE:     take = ~is_zero_s;
            CC_GE:     take = ~is_neg_s;
            CC_GT:     take = ~is_neg_s & ~is_zero_s;
            default:   take = 1'b0;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetches over req/ack, decodes the opcode class and
// drives register-file/ALU selects, write strobes and the program counter.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    control_sequencer_if.master imem,
    input  logic [DATA_W-1:0]   jump_target,
    input  logic [DATA_W-1:0]   cond_value,
    output logic [DATA_W-1:0]   instruction,
    output logic [1:0]          opcode,
    output logic [2:0]          iaddr,
    output logic [2:0]          oaddr,
    output logic [2:0]          alu_mode,
    output logic                imm_en,
    output logic [DATA_W-1:0]   imm_value,
    output logic                reg_we,
    output logic                oport_we,
    output logic [1:0]          state
);
    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] target_r;
    logic [DATA_W-1:0] instr_r;
    logic              req_r;
    logic              jump_r;
    logic [1:0]        opcode_r;
    logic [2:0]        iaddr_r;
    logic [2:0]        oaddr_r;
    logic [2:0]        alu_mode_r;
    logic              imm_en_r;
    logic              reg_we_r;
    logic              oport_we_r;

    logic [2:0]        dec_iaddr_s;
    logic [2:0]        dec_oaddr_s;
    logic [2:0]        dec_alu_mode_s;
    logic              dec_imm_en_s;
    logic              exe_reg_we_s;
    logic              exe_port_we_s;
    logic              exe_jump_s;
    logic              take_s;

    cond_eval #(.DATA_W(DATA_W)) u_cond_eval (
        .cc         (instr_r[2:0]),
        .cond_value (cond_value),
        .take       (take_s)
    );

    // Field extraction from the latched instruction word.
    always_comb begin
        dec_iaddr_s    = 3'd0;
        dec_oaddr_s    = 3'd0;
        dec_alu_mode_s = 3'd0;
        dec_imm_en_s   = 1'b0;
        case (instr_r[7:6])
            OP_IMM: begin
                dec_oaddr_s  = IMM_SEL;
                dec_imm_en_s = 1'b1;
            end
            OP_ALU: begin
                dec_iaddr_s    = 3'd0;
                dec_oaddr_s    = ACC_SEL;
                dec_alu_mode_s = instr_r[2:0];
            end
            OP_COPY: begin
                dec_iaddr_s = instr_r[5:3];
                dec_oaddr_s = instr_r[2:0];
            end
            OP_COND: begin
                dec_oaddr_s = 3'd0;
            end
            default: begin
                dec_oaddr_s = 3'd0;
            end
        endcase
    end

    // Writeback strobes and branch decision, resolved while selects are stable.
    always_comb begin
        exe_reg_we_s  = 1'b0;
        exe_port_we_s = 1'b0;
        exe_jump_s    = 1'b0;
        case (opcode_r)
            OP_IMM, OP_ALU: exe_reg_we_s = 1'b1;
            OP_COPY: begin
                if (oaddr_r == PORT_SEL) begin
                    exe_port_we_s = 1'b1;
                end else if (oaddr_r == UNMAPPED_SEL) begin
                    exe_reg_we_s = 1'b0;
                end else begin
                    exe_reg_we_s = 1'b1;
                end
            end
            OP_COND: exe_jump_s = take_s;
            default: exe_jump_s = 1'b0;
        endcase
    end

    // Sequencer FSM with pc, fetch request, decode and strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= {ADDR_W{1'b0}};
            target_r   <= {ADDR_W{1'b0}};
            instr_r    <= {DATA_W{1'b0}};
            req_r      <= 1'b0;
            jump_r     <= 1'b0;
            opcode_r   <= 2'd0;
            iaddr_r    <= 3'd0;
            oaddr_r    <= 3'd0;
            alu_mode_r <= 3'd0;
            imm_en_r   <= 1'b0;
            reg_we_r   <= 1'b0;
            oport_we_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    reg_we_r   <= 1'b0;
                    oport_we_r <= 1'b0;
                    if (req_r && imem.imem_ack) begin
                        instr_r <= imem.imem_data;
                        req_r   <= 1'b0;
                        state_r <= ST_DECODE;
                    end else begin
                        req_r   <= run;
                    end
                end
                ST_DECODE: begin
                    opcode_r   <= instr_r[7:6];
                    iaddr_r    <= dec_iaddr_s;
                    oaddr_r    <= dec_oaddr_s;
                    alu_mode_r <= dec_alu_mode_s;
                    imm_en_r   <= dec_imm_en_s;
                    state_r    <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    reg_we_r   <= exe_reg_we_s;
                    oport_we_r <= exe_port_we_s;
                    jump_r     <= exe_jump_s;
                    target_r   <= jump_target[ADDR_W-1:0];
                    state_r    <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    reg_we_r   <= 1'b0;
                    oport_we_r <= 1'b0;
                    pc_r       <= jump_r ? target_r : (pc_r + {{(ADDR_W-1){1'b0}}, 1'b1});
                    // Raise the next request immediately so a zero-wait ack keeps 4-cycle throughput.
                    req_r      <= run;
                    state_r    <= ST_FETCH;
                end
                default: begin
                    reg_we_r   <= 1'b0;
                    oport_we_r <= 1'b0;
                    req_r      <= 1'b0;
                    state_r    <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem.imem_addr = pc_r;
    assign imem.imem_req  = req_r;
    assign instruction    = instr_r;
    assign opcode         = opcode_r;
    assign iaddr          = iaddr_r;
    assign oaddr          = oaddr_r;
    assign alu_mode       = alu_mode_r;
    assign imm_en         = imm_en_r;
    assign imm_value      = {{(DATA_W-6){1'b0}}, instr_r[5:0]};
    assign reg_we         = reg_we_r;
    assign oport_we       = oport_we_r;
    assign state          = state_r;
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed corner cases followed by
// randomized instructions, compared against an instruction-level reference model.
module tb_control_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] jump_target;
    logic [7:0] cond_value;
    logic [7:0] instruction;
    logic [1:0] opcode;
    logic [2:0] iaddr;
    logic [2:0] oaddr;
    logic [2:0] alu_mode;
    logic       imm_en;
    logic [7:0] imm_value;
    logic       reg_we;
    logic       oport_we;
    logic [1:0] state;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .imem        (bus),
        .jump_target (jump_target),
        .cond_value  (cond_value),
        .instruction (instruction),
        .opcode      (opcode),
        .iaddr       (iaddr),
        .oaddr       (oaddr),
        .alu_mode    (alu_mode),
        .imm_en      (imm_en),
        .imm_value   (imm_value),
        .reg_we      (reg_we),
        .oport_we    (oport_we),
        .state       (state)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] m_pc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Condition outcome straight from the signed-compare table.
    function automatic bit cond_true(input logic [2:0] cc, input logic [7:0] cv);
        int v;
        v = $signed(cv);
        case (cc)
            3'd0:    return 1'b0;
            3'd1:    return v == 0;
            3'd2:    return v < 0;
            3'd3:    return v <= 0;
            3'd4:    return 1'b1;
            3'd5:    return v != 0;
            3'd6:    return v >= 0;
            3'd7:    return v > 0;
            default: return 1'b0;
        endcase
    endfunction

    // Execute one instruction through the handshake and check every phase.
    task automatic exec_instr(input logic [7:0] instr, input logic [7:0] jt,
                              input logic [7:0] cv, input int waits);
        logic [1:0] op;
        logic [7:0] e_pc;
        logic [2:0] e_iaddr, e_oaddr;
        bit         e_reg, e_port, chk_sel;
        int         lat, guard;

        op      = instr[7:6];
        e_pc    = m_pc + 8'd1;
        e_reg   = 1'b0;
        e_port  = 1'b0;
        chk_sel = 1'b1;
        e_iaddr = 3'd0;
        e_oaddr = 3'd0;
        if (op == 2'b00) begin
            e_reg = 1'b1;
        end else if (op == 2'b01) begin
            e_reg = 1'b1;
            e_oaddr = 3'd3;
        end else if (op == 2'b10) begin
            e_iaddr = instr[5:3];
            e_oaddr = instr[2:0];
            e_port  = (instr[2:0] == 3'd6);
            e_reg   = (instr[2:0] < 3'd6);
        end else begin
            chk_sel = 1'b0;
            if (cond_true(instr[2:0], cv)) e_pc = jt;
        end

        jump_target   = jt;
        cond_value    = cv;
        run           = 1'b1;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'($urandom);
        guard = 0;
        while (bus.imem_req !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check_eq("req_raised", 32'(bus.imem_req), 32'd1);
        check_eq("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        lat = 1;
        repeat (waits) begin
            step();
            lat++;
            check_eq("wait_state", 32'(state), 32'd0);
            check_eq("wait_req_held", 32'(bus.imem_req), 32'd1);
        end
        bus.imem_ack  = 1'b1;
        bus.imem_data = instr;
        step();
        lat++;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'($urandom);
        check_eq("decode_state", 32'(state), 32'd1);
        check_eq("decode_no_strobe", 32'({reg_we, oport_we}), 32'd0);
        guard = 0;
        while (state !== 2'd3 && guard < 8) begin
            step();
            lat++;
            guard++;
        end
        check_eq("latency", 32'(lat), 32'(waits + 4));
        check_eq("wb_instruction", 32'(instruction), 32'(instr));
        check_eq("wb_opcode", 32'(opcode), 32'(op));
        check_eq("wb_imm_en", 32'(imm_en), 32'(op == 2'b00));
        check_eq("wb_imm_value", 32'(imm_value), 32'({2'b00, instr[5:0]}));
        check_eq("wb_reg_we", 32'(reg_we), 32'(e_reg));
        check_eq("wb_oport_we", 32'(oport_we), 32'(e_port));
        check_eq("wb_req_low", 32'(bus.imem_req), 32'd0);
        if (chk_sel) begin
            check_eq("wb_oaddr", 32'(oaddr), 32'(e_oaddr));
            if (op != 2'b00) check_eq("wb_iaddr", 32'(iaddr), 32'(e_iaddr));
            if (op == 2'b01) check_eq("wb_alu_mode", 32'(alu_mode), 32'(instr[2:0]));
        end
        step();
        check_eq("next_state", 32'(state), 32'd0);
        check_eq("next_strobes", 32'({reg_we, oport_we}), 32'd0);
        check_eq("next_pc", 32'(bus.imem_addr), 32'(e_pc));
        if (chk_sel) check_eq("oaddr_hold", 32'(oaddr), 32'(e_oaddr));
        m_pc = e_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cvals [3];
        logic [7:0] r_instr, r_cv;
        cvals[0] = 8'h00;
        cvals[1] = 8'h80;
        cvals[2] = 8'h05;

        reset = 1'b1;
        run = 1'b0;
        jump_target = 8'h00;
        cond_value = 8'h00;
        bus.imem_ack = 1'b0;
        bus.imem_data = 8'h00;
        step();
        step();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pc", 32'(bus.imem_addr), 32'd0);
        check_eq("rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_instruction", 32'(instruction), 32'd0);
        check_eq("rst_strobes_sel", 32'({reg_we, oport_we, imm_en, iaddr, oaddr, alu_mode}), 32'd0);
        reset = 1'b0;
        m_pc = 8'h00;
        // Held in FETCH while run is low, acks ignored.
        bus.imem_ack = 1'b1;
        step();
        step();
        check_eq("idle_no_req", 32'(bus.imem_req), 32'd0);
        check_eq("idle_ack_ignored", 32'(state), 32'd0);
        bus.imem_ack = 1'b0;

        exec_instr(8'h2A, 8'h00, 8'h00, 0);
        exec_instr(8'b10_110_011, 8'h00, 8'h00, 0);
        exec_instr(8'b10_001_110, 8'h00, 8'h00, 0);
        for (int v = 0; v < 3; v++) begin
            for (int cc = 0; cc < 8; cc++) begin
                exec_instr({5'b11_000, 3'(cc)}, 8'h40, cvals[v], 0);
            end
        end
        exec_instr(8'b11_000_100, 8'hFF, 8'h00, 1);
        check_eq("pc_at_ff", 32'(m_pc), 32'hFF);
        exec_instr(8'b01_000_101, 8'h00, 8'h00, 0);

        // run dropped mid-request: request withdrawn, ack without request ignored.
        step();
        check_eq("pending_req", 32'(bus.imem_req), 32'd1);
        run = 1'b0;
        step();
        check_eq("run_low_req_drop", 32'(bus.imem_req), 32'd0);
        bus.imem_ack = 1'b1;
        bus.imem_data = 8'h2A;
        step();
        check_eq("ack_no_req_state", 32'(state), 32'd0);
        step();
        check_eq("ack_no_req_state2", 32'(state), 32'd0);
        exec_instr(8'b10_010_110, 8'h00, 8'h00, 3);

        // Asynchronous reset in the middle of a pending fetch.
        check_eq("pre_reset_req", 32'(bus.imem_req), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("async_rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("async_rst_state", 32'(state), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("post_rst_pc", 32'(bus.imem_addr), 32'd0);
        m_pc = 8'h00;

        for (int i = 0; i < 150; i++) begin
            r_instr = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       r_cv = 8'h00;
                1:       r_cv = 8'h80;
                default: r_cv = 8'($urandom);
            endcase
            exec_instr(r_instr, 8'($urandom), r_cv, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
